// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the
// pipeline WB stage and a multi-cycle unit (MDU) whose results are held in a
// small FIFO.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   pipe_write/reg/data      WB stage write request
//   mdu_valid/reg/data       MDU result offer
//   mdu_ready                FIFO can take an MDU result this cycle
//   stall_req                registered one-cycle hold of the WB stage
//   rf_we/rf_waddr/rf_wdata  register-file write port (combinational)
//   pend_mask                one bit per register targeted by a buffered entry
//
// Optional feature: define WB_ARB_BYPASS_EN to let an MDU result go straight
// to the write port when the FIFO is empty and the pipeline is not writing.
module wb_port_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_write,
  input  logic [4:0]  pipe_reg,
  input  logic [31:0] pipe_data,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_reg,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        stall_req,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pend_mask
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  logic [4:0]            ent_reg  [FIFO_DEPTH];
  logic [31:0]           ent_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] ent_vld;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [STV_W-1:0]      starve_cnt;

  logic pipe_grant, fifo_grant, fifo_empty, head_drop;
  logic pop, push, keep, bypass, starve_inc, starve_hit;

  assign mdu_ready = (count < CNT_W'(FIFO_DEPTH));

  // Grant selection and write-port mux.
  always_comb begin
    fifo_empty = (count == '0);
    pipe_grant = pipe_write && !stall_req && (pipe_reg != 5'd0);
    fifo_grant = !pipe_grant && !fifo_empty;
    // An older buffered result to the same register is superseded by the
    // pipeline write, so it is retired silently.
    head_drop  = pipe_grant && !fifo_empty && (ent_reg[rd_ptr] == pipe_reg);
    pop        = fifo_grant || head_drop;
    keep       = mdu_valid && mdu_ready && (mdu_reg != 5'd0);
`ifdef WB_ARB_BYPASS_EN
    bypass     = keep && fifo_empty && !pipe_grant;
`else
    bypass     = 1'b0;
`endif
    push       = keep && !bypass;
    starve_inc = pipe_grant && !fifo_empty;
    starve_hit = starve_inc && (starve_cnt == STV_W'(STARVE_LIMIT - 1));

    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (pipe_grant) begin
      rf_we    = 1'b1;
      rf_waddr = pipe_reg;
      rf_wdata = pipe_data;
    end else if (fifo_grant) begin
      rf_we    = 1'b1;
      rf_waddr = ent_reg[rd_ptr];
      rf_wdata = ent_data[rd_ptr];
    end else if (bypass) begin
      rf_we    = 1'b1;
      rf_waddr = mdu_reg;
      rf_wdata = mdu_data;
    end
  end

  // FIFO control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (push) begin
        wr_ptr          <= wr_ptr + PTR_W'(1);
        ent_vld[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr          <= rd_ptr + PTR_W'(1);
        ent_vld[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO payload storage; qualified by ent_vld so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_reg[wr_ptr]  <= mdu_reg;
      ent_data[wr_ptr] <= mdu_data;
    end
  end

  // Starvation counter: forces a one-cycle pipeline hold so the FIFO drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else begin
      stall_req <= starve_hit;
      if (fifo_grant || fifo_empty || starve_hit) begin
        starve_cnt <= '0;
      end else if (starve_inc) begin
        starve_cnt <= starve_cnt + STV_W'(1);
      end
    end
  end

  // Pending-register mask from buffered entries only.
  always_comb begin
    pend_mask = 32'd0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (ent_vld[i]) pend_mask[ent_reg[i]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter. Expected register-file writes are
// queued as stimulus is driven and retired by a monitor on every write.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        pipe_write;
  logic [4:0]  pipe_reg;
  logic [31:0] pipe_data;
  logic        mdu_valid;
  logic [4:0]  mdu_reg;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        stall_req;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pend_mask;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks   = 0;
  int  failures = 0;

`ifdef WB_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  wb_port_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_write(pipe_write), .pipe_reg(pipe_reg), .pipe_data(pipe_data),
    .mdu_valid(mdu_valid), .mdu_reg(mdu_reg), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready), .stall_req(stall_req),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_mask(pend_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Retire one expected write for every write the DUT issues.
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got reg=%0d data=%h expected no write", rf_waddr, rf_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (rf_waddr !== mon_e.r || rf_wdata !== mon_e.d) begin
          failures++;
          $display("FAIL write_order got reg=%0d data=%h expected reg=%0d data=%h",
                   rf_waddr, rf_wdata, mon_e.r, mon_e.d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
    wr_t e;
    e.r = r;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Advance to just after the next rising edge and apply inputs.
  task automatic drive(input logic pw, input logic [4:0] pr, input logic [31:0] pd,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    @(posedge clk);
    #1;
    pipe_write = pw; pipe_reg = pr; pipe_data = pd;
    mdu_valid  = mv; mdu_reg  = mr; mdu_data  = md;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pipe_write = 1'b0; pipe_reg = 5'd0; pipe_data = 32'd0;
    mdu_valid  = 1'b0; mdu_reg  = 5'd0; mdu_data  = 32'd0;
    #2;
    checks++;
    if (mdu_ready !== 1'b1 || stall_req !== 1'b0 || pend_mask !== 32'd0 || rf_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got ready=%b stall=%b pend=%h we=%b expected 1 0 0 0",
               mdu_ready, stall_req, pend_mask, rf_we);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_pipe_write();
    expect_wr(5'd5, 32'hDEADBEEF);
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL pipe_same_cycle got we=%b reg=%0d data=%h expected 1 5 deadbeef",
               rf_we, rf_waddr, rf_wdata);
    end
    idle();
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0) begin
      failures++;
      $display("FAIL pipe_idle got we=%b expected 0", rf_we);
    end
  endtask

  task automatic test_mdu_single();
    expect_wr(5'd8, 32'h12);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h12);
    @(negedge clk);
    checks++;
    if (rf_we !== BYP) begin
      failures++;
      $display("FAIL mdu_cycle0_we got %b expected %b", rf_we, BYP);
    end
    idle();
    @(negedge clk);
    checks++;
    if (rf_we !== !BYP || pend_mask[8] !== !BYP) begin
      failures++;
      $display("FAIL mdu_cycle1 got we=%b pend8=%b expected %b %b", rf_we, pend_mask[8], !BYP, !BYP);
    end
    idle();
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || pend_mask !== 32'd0) begin
      failures++;
      $display("FAIL mdu_drained got we=%b pend=%h expected 0 0", rf_we, pend_mask);
    end
  endtask

  task automatic test_starve();
    expect_wr(5'd3, 32'h300);
    drive(1'b1, 5'd3, 32'h300, 1'b1, 5'd10, 32'hA0);
    expect_wr(5'd3, 32'h301);
    drive(1'b1, 5'd3, 32'h301, 1'b1, 5'd11, 32'hB0);
    expect_wr(5'd3, 32'h302);
    drive(1'b1, 5'd3, 32'h302, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (mdu_ready !== 1'b0 || pend_mask !== 32'h0000_0C00 || stall_req !== 1'b0) begin
      failures++;
      $display("FAIL starve_full got ready=%b pend=%h stall=%b expected 0 00000c00 0",
               mdu_ready, pend_mask, stall_req);
    end
    expect_wr(5'd3, 32'h303);
    drive(1'b1, 5'd3, 32'h303, 1'b0, 5'd0, 32'd0);
    expect_wr(5'd3, 32'h304);
    drive(1'b1, 5'd3, 32'h304, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (stall_req !== 1'b0) begin
      failures++;
      $display("FAIL starve_pre_stall got stall=%b expected 0", stall_req);
    end
    expect_wr(5'd10, 32'hA0);
    drive(1'b1, 5'd3, 32'h305, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (stall_req !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd10) begin
      failures++;
      $display("FAIL starve_stall got stall=%b we=%b reg=%0d expected 1 1 10",
               stall_req, rf_we, rf_waddr);
    end
    expect_wr(5'd3, 32'h305);
    drive(1'b1, 5'd3, 32'h305, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (stall_req !== 1'b0) begin
      failures++;
      $display("FAIL starve_one_cycle got stall=%b expected 0", stall_req);
    end
    expect_wr(5'd11, 32'hB0);
    idle();
    idle();
    @(negedge clk);
    checks++;
    if (pend_mask !== 32'd0 || rf_we !== 1'b0 || mdu_ready !== 1'b1) begin
      failures++;
      $display("FAIL starve_drained got pend=%h we=%b ready=%b expected 0 0 1",
               pend_mask, rf_we, mdu_ready);
    end
  endtask

  task automatic test_collision();
    expect_wr(5'd4, 32'h44);
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'h99);
    expect_wr(5'd9, 32'hAA);
    drive(1'b1, 5'd9, 32'hAA, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (rf_wdata !== 32'hAA || pend_mask !== 32'h0000_0200) begin
      failures++;
      $display("FAIL collide_write got data=%h pend=%h expected aa 00000200", rf_wdata, pend_mask);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b0 || pend_mask !== 32'd0) begin
        failures++;
        $display("FAIL collide_dropped got we=%b pend=%h expected 0 0", rf_we, pend_mask);
      end
    end
  endtask

  task automatic test_reg_zero();
    drive(1'b1, 5'd0, 32'h5555, 1'b1, 5'd0, 32'h6666);
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0) begin
      failures++;
      $display("FAIL zero_no_write got we=%b expected 0", rf_we);
    end
    idle();
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || pend_mask !== 32'd0 || mdu_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_not_stored got we=%b pend=%h ready=%b expected 0 0 1",
               rf_we, pend_mask, mdu_ready);
    end
  endtask

  task automatic test_reset_mid();
    expect_wr(5'd3, 32'h500);
    drive(1'b1, 5'd3, 32'h500, 1'b1, 5'd12, 32'hC);
    expect_wr(5'd3, 32'h501);
    drive(1'b1, 5'd3, 32'h501, 1'b1, 5'd13, 32'hD);
    expect_wr(5'd3, 32'h502);
    drive(1'b1, 5'd3, 32'h502, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (mdu_ready !== 1'b0 || pend_mask !== 32'h0000_3000) begin
      failures++;
      $display("FAIL rstmid_loaded got ready=%b pend=%h expected 0 00003000", mdu_ready, pend_mask);
    end
    #2;
    pipe_write = 1'b0; pipe_reg = 5'd0; pipe_data = 32'd0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mdu_ready !== 1'b1 || pend_mask !== 32'd0 || stall_req !== 1'b0 || rf_we !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async got ready=%b pend=%h stall=%b we=%b expected 1 0 0 0",
               mdu_ready, pend_mask, stall_req, rf_we);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_no_write got we=%b expected 0", rf_we);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_mdu_single();
    test_starve();
    test_collision();
    test_reg_zero();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_writes got %0d outstanding expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
